// File: rtl/cpu_mem_responder.sv
// Memory/MMIO responder for a small CPU: registered instruction and data ports,
// byte-lane data writes, a sticky error flag and a RUN/DRAIN/HALTED halt sequencer.
module cpu_mem_responder #(
    parameter int          IM_WORDS  = 16384,
    parameter int          DM_WORDS  = 16384,
    parameter logic [31:0] DM_BASE   = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        err,
    output logic        halt
);
    localparam int          IM_AW  = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
    localparam int          DM_AW  = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [32:0] DM_END = {1'b0, DM_BASE} + 33'(4 * DM_WORDS);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t      state;
    logic [1:0]  drain_cnt;
    logic [31:0] cycle;

    // Contents come from simulation preload only; reset never touches them.
    logic [31:0] im [IM_WORDS];
    logic [31:0] dm [DM_WORDS];

    logic [29:0]      i_word;
    logic             i_oob;
    logic [IM_AW-1:0] im_idx;
    logic [31:0]      d_aligned;
    logic [31:0]      mmio_off;
    logic             dm_hit;
    logic             mmio_hit;
    logic [1:0]       mmio_sel;
    logic [DM_AW-1:0] dm_idx;
    logic             d_access;
    logic             writable;
    logic             dm_we;
    logic             halt_req;
    logic             err_set;
    logic             err_clr;
    logic [31:0]      rd_word;

    assign i_word = instr_addr[31:2];
    assign i_oob  = {2'b00, i_word} >= 32'(IM_WORDS);
    assign im_idx = IM_AW'(i_word);

    // Misaligned data accesses still proceed on the enclosing word.
    assign d_aligned = {data_addr[31:2], 2'b00};
    assign dm_hit    = ({1'b0, d_aligned} >= {1'b0, DM_BASE}) && ({1'b0, d_aligned} < DM_END);
    assign dm_idx    = DM_AW'((d_aligned - DM_BASE) >> 2);
    assign mmio_off  = d_aligned - MMIO_BASE;
    assign mmio_hit  = (d_aligned >= MMIO_BASE) && (mmio_off < 32'd12);
    assign mmio_sel  = mmio_off[3:2];

    assign d_access = data_read || (data_write != 4'b0000);
    assign writable = (state != S_HALTED);
    assign dm_we    = rst && writable && dm_hit && (data_write != 4'b0000);
    assign halt_req = writable && (state == S_RUN) && mmio_hit && (mmio_sel == 2'd0)
                      && data_write[0] && data_in[0];
    assign err_clr  = writable && mmio_hit && (mmio_sel == 2'd2) && data_write[0] && data_in[0];
    assign err_set  = (instr_read && (i_oob || (instr_addr[1:0] != 2'b00)))
                      || (d_access && ((!dm_hit && !mmio_hit) || (data_addr[1:0] != 2'b00)));

    always_comb begin
        rd_word = 32'h0;
        if (dm_hit) begin
            rd_word = dm[dm_idx];
        end else if (mmio_hit) begin
            case (mmio_sel)
                2'd0:    rd_word = {31'b0, halt};
                2'd1:    rd_word = cycle;
                2'd2:    rd_word = {31'b0, err};
                default: rd_word = 32'h0;
            endcase
        end
    end

    // Data memory: the read above sees the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (dm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_write[i]) dm[dm_idx][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out <= 32'h0;
            data_out  <= 32'h0;
            err       <= 1'b0;
            halt      <= 1'b0;
            cycle     <= 32'h0;
            state     <= S_RUN;
            drain_cnt <= 2'd0;
        end else begin
            if (instr_read) instr_out <= i_oob ? NOP : im[im_idx];
            if (data_read)  data_out  <= rd_word;

            // A coincident error event wins over a write-1-clear.
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            if (state != S_HALTED) cycle <= cycle + 32'd1;

            case (state)
                S_RUN: begin
                    if (halt_req) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd1) begin
                        state     <= S_HALTED;
                        halt      <= 1'b1;
                        drain_cnt <= 2'd0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized scoreboard bench for cpu_mem_responder; expectations come from a
// per-edge reference model over plain arrays and edge arithmetic.
module tb_cpu_mem_responder;
    localparam int          IMW = 256;
    localparam int          DMW = 256;
    localparam logic [31:0] DMB = 32'h0001_0000;
    localparam logic [31:0] MMB = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic        data_read;
    logic [31:0] data_addr;
    logic [3:0]  data_write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        err;
    logic        halt;

    cpu_mem_responder #(
        .IM_WORDS (IMW),
        .DM_WORDS (DMW),
        .DM_BASE  (DMB),
        .MMIO_BASE(MMB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_read(instr_read),
        .instr_addr(instr_addr),
        .instr_out (instr_out),
        .data_read (data_read),
        .data_addr (data_addr),
        .data_write(data_write),
        .data_in   (data_in),
        .data_out  (data_out),
        .err       (err),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] im_m [IMW];
    logic [31:0] dm_m [DMW];
    logic        err_m;
    logic [31:0] i_hold;
    logic [31:0] d_hold;
    int          edge_n;
    int          req_edge;

    logic [31:0] exp_i [$];
    logic [31:0] exp_d [$];
    logic [1:0]  exp_s [$];

    int   tests;
    int   fails;
    logic active;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge e counts edges since reset release; the halt request edge is req_edge.
    function automatic logic halted_before(input int e);
        return (req_edge >= 0) && (e >= req_edge + 3);
    endfunction

    function automatic logic [31:0] cyc_before(input int e);
        if (req_edge < 0 || e < req_edge + 3) return 32'(e);
        return 32'(req_edge + 3);
    endfunction

    task automatic do_cycle(input logic ird, input logic [31:0] iaddr, input logic drd,
                            input logic [31:0] daddr, input logic [3:0] we, input logic [31:0] din);
        int          e;
        int          ii;
        int          di;
        int          mo;
        logic        hb;
        logic        set;
        logic        clr;
        logic        in_dm;
        logic        in_mm;
        logic        h_after;
        logic [31:0] wa;
        @(negedge clk);
        instr_read = ird;
        instr_addr = iaddr;
        data_read  = drd;
        data_addr  = daddr;
        data_write = we;
        data_in    = din;
        active     = 1'b1;

        e     = edge_n;
        hb    = halted_before(e);
        wa    = {daddr[31:2], 2'b00};
        in_dm = (wa >= DMB) && (wa < DMB + 32'(4 * DMW));
        in_mm = (wa >= MMB) && ((wa - MMB) < 32'd12);
        di    = int'((wa - DMB) >> 2);
        mo    = int'((wa - MMB) >> 2);
        set   = 1'b0;
        clr   = 1'b0;

        if (ird) begin
            ii = int'(iaddr >> 2);
            if ((iaddr >> 2) >= 32'(IMW)) begin
                i_hold = 32'h0000_0013;
                set    = 1'b1;
            end else begin
                i_hold = im_m[ii];
            end
            if (iaddr[1:0] != 2'b00) set = 1'b1;
        end

        if (drd) begin
            if (in_dm)               d_hold = dm_m[di];
            else if (in_mm && mo == 0) d_hold = {31'b0, hb};
            else if (in_mm && mo == 1) d_hold = cyc_before(e);
            else if (in_mm)          d_hold = {31'b0, err_m};
            else                     d_hold = 32'h0;
        end

        if (drd || we != 4'b0000) begin
            if (!in_dm && !in_mm) set = 1'b1;
            if (daddr[1:0] != 2'b00) set = 1'b1;
        end

        if (!hb && we != 4'b0000) begin
            if (in_dm) begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) dm_m[di][8*i +: 8] = din[8*i +: 8];
            end
            if (in_mm && mo == 0 && we[0] && din[0] && req_edge < 0) req_edge = e;
            if (in_mm && mo == 2 && we[0] && din[0]) clr = 1'b1;
        end

        err_m   = set | (err_m & ~clr);
        h_after = (req_edge >= 0) && (e >= req_edge + 2);
        edge_n++;

        exp_i.push_back(i_hold);
        exp_d.push_back(d_hold);
        exp_s.push_back({err_m, h_after});
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        do_cycle(1'b0, 32'h0, 1'b0, a, we, d);
    endtask

    task automatic rd(input logic [31:0] a);
        do_cycle(1'b0, 32'h0, 1'b1, a, 4'b0000, 32'h0);
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    endtask

    // Reset drops between edges and is released just after a rising edge.
    task automatic apply_reset();
        @(negedge clk);
        active     = 1'b0;
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 4'b0000;
        #2 rst = 1'b0;
        #1;
        check("reset_instr_out", instr_out, 32'h0);
        check("reset_data_out", data_out, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_halt", {31'b0, halt}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        edge_n   = 0;
        req_edge = -1;
        err_m    = 1'b0;
        i_hold   = 32'h0;
        d_hold   = 32'h0;
    endtask

    task automatic random_cycle();
        logic        ird;
        logic        drd;
        logic [31:0] ia;
        logic [31:0] da;
        logic [3:0]  we;
        int          r;
        ird = 1'($urandom_range(0, 1));
        r   = int'($urandom_range(0, 15));
        if (r == 0)      ia = 32'(4 * IMW) + 32'(4 * $urandom_range(0, 100));
        else if (r == 1) ia = 32'(4 * $urandom_range(0, IMW - 1)) + 32'($urandom_range(1, 3));
        else             ia = 32'(4 * $urandom_range(0, IMW - 1));
        r = int'($urandom_range(0, 9));
        if (r <= 6)      da = DMB + 32'(4 * $urandom_range(0, DMW - 1));
        else if (r == 7) da = MMB + 32'(4 * $urandom_range(1, 2));
        else             da = 32'h0000_8000 + 32'(4 * $urandom_range(0, 1000));
        if ($urandom_range(0, 11) == 0) da = da + 32'($urandom_range(1, 3));
        drd = 1'($urandom_range(0, 1));
        we  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        do_cycle(ird, ia, drd, da, we, $urandom);
    endtask

    // Monitor: pops one expectation set for each edge the driver owned.
    initial begin : monitor
        logic        a;
        logic [31:0] ei;
        logic [31:0] ed;
        logic [1:0]  es;
        forever begin
            @(posedge clk);
            a = active;
            @(negedge clk);
            if (a) begin
                if (exp_s.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
                end else begin
                    ei = exp_i.pop_front();
                    ed = exp_d.pop_front();
                    es = exp_s.pop_front();
                    check("instr_out", instr_out, ei);
                    check("data_out", data_out, ed);
                    check("err", {31'b0, err}, {31'b0, es[1]});
                    check("halt", {31'b0, halt}, {31'b0, es[0]});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        tests      = 0;
        fails      = 0;
        active     = 1'b0;
        rst        = 1'b0;
        instr_read = 1'b0;
        instr_addr = 32'h0;
        data_read  = 1'b0;
        data_addr  = 32'h0;
        data_write = 4'b0000;
        data_in    = 32'h0;
        for (int i = 0; i < IMW; i++) begin
            im_m[i] = (i == 3) ? 32'h00A0_0093 : $urandom;
            dut.im[i] = im_m[i];
        end

        apply_reset();

        for (int i = 0; i < DMW; i++) wr(DMB + 32'(4 * i), 4'hF, $urandom);
        wr(DMB, 4'hF, 32'h1122_3344);
        wr(DMB + 32'h8, 4'hF, 32'h0000_0005);

        // Instruction fetch, out-of-range fetch, hold while idle
        do_cycle(1'b1, 32'hC, 1'b0, 32'h0, 4'b0000, 32'h0);
        idle_cycle();
        do_cycle(1'b1, 32'(4 * IMW), 1'b0, 32'h0, 4'b0000, 32'h0);
        wr(MMB + 32'h8, 4'b0001, 32'h1);

        // Lane-masked write, then same-edge read/write to one word
        wr(DMB, 4'b0101, 32'hAABB_CCDD);
        rd(DMB);
        do_cycle(1'b0, 32'h0, 1'b1, DMB + 32'h8, 4'hF, 32'hDEAD_BEEF);
        rd(DMB + 32'h8);

        // Unmapped access, clear, and clear losing to a coincident error
        wr(32'h0000_8000, 4'hF, 32'h1234_5678);
        rd(32'h0000_8000);
        wr(MMB + 32'h8, 4'b0001, 32'h1);
        rd(MMB + 32'h8);
        do_cycle(1'b1, 32'h1, 1'b0, MMB + 32'h8, 4'b0001, 32'h1);
        rd(MMB + 32'h8);
        rd(MMB + 32'h4);
        rd(MMB + 32'h4);
        rd(MMB);

        repeat (300) random_cycle();

        // Halt sequence and behaviour once halted
        wr(MMB, 4'b0001, 32'h1);
        repeat (4) rd(MMB);
        wr(DMB + 32'h14, 4'hF, 32'hCAFE_F00D);
        rd(DMB + 32'h14);
        repeat (10) rd(MMB + 32'h4);
        wr(MMB + 32'h8, 4'b0001, 32'h1);

        // Reset in the middle of DRAIN
        apply_reset();
        rd(MMB + 32'h4);
        rd(MMB + 32'h4);
        rd(DMB + 32'h1);
        wr(MMB, 4'b0001, 32'h1);
        idle_cycle();
        apply_reset();
        idle_cycle();
        rd(MMB + 32'h4);
        wr(MMB, 4'b0001, 32'h1);
        repeat (4) rd(MMB);
        apply_reset();

        repeat (200) random_cycle();

        @(negedge clk);
        active = 1'b0;
        repeat (2) @(posedge clk);
        tests++;
        if (exp_s.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_s.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
